// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} dmem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Loads reject 011/110/111; stores reject any unsigned form and 011.
  function automatic logic f3_illegal(input logic wr, input logic [2:0] f3);
    if (wr) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed backing store: 4-lane port starting at addr_i, synchronous write,
// combinational read.
module dmem_byte_array #(
  parameter int    MEM_DEPTH = 1048576,
  parameter string MEM_PATH  = "",
  localparam int   AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] mem_q [MEM_DEPTH];

  // Lane i maps to byte addr_i+i; wrap is harmless since crossing accesses never commit.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) mem_q[AW'(addr_i + AW'(i))] <= wdata_i[8*i +: 8];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rdata_o[8*i +: 8] = mem_q[AW'(addr_i + AW'(i))];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with fixed LATENCY and a single outstanding request.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of force-aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h02000000,
  parameter int                MEM_DEPTH = 1048576,
  parameter int                LATENCY   = 2,
  parameter string             MEM_PATH  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int MAW = $clog2(MEM_DEPTH);

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept, commit, mem_we, acc_err, misalign, oor;
  logic              a_write;
  logic [AWIDTH-1:0] a_addr, offset, off_al;
  logic [2:0]        a_f3, nbytes;
  logic [1:0]        sz;
  logic [3:0]        be;
  logic [DWIDTH-1:0] a_wdata, mem_rdata, ext;

  assign req_ready_o = (state_q == IDLE) && !rst;
  assign accept      = req_ready_o && req_valid_i;

  // With LATENCY==1 the access commits on the accept edge, so decode the live inputs in IDLE.
  assign a_write = (state_q == IDLE) ? req_write_i  : write_q;
  assign a_addr  = (state_q == IDLE) ? req_addr_i   : addr_q;
  assign a_f3    = (state_q == IDLE) ? req_funct3_i : f3_q;
  assign a_wdata = (state_q == IDLE) ? req_wdata_i  : wdata_q;

  assign offset = a_addr - BASE_ADDR;
  assign sz     = a_f3[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((sz == SZ_H) && offset[0]) || ((sz == SZ_W) && (offset[1:0] != 2'b00));
  assign off_al   = offset;
`else
  assign misalign = 1'b0;
  assign off_al   = (sz == SZ_H) ? {offset[AWIDTH-1:1], 1'b0} :
                    (sz == SZ_W) ? {offset[AWIDTH-1:2], 2'b00} : offset;
`endif

  always_comb begin
    nbytes = 3'd1;
    be     = 4'b0000;
    case (sz)
      SZ_B:    begin nbytes = 3'd1; be = 4'b0001; end
      SZ_H:    begin nbytes = 3'd2; be = 4'b0011; end
      SZ_W:    begin nbytes = 3'd4; be = 4'b1111; end
      default: begin nbytes = 3'd1; be = 4'b0000; end
    endcase
  end

  assign oor     = ({1'b0, off_al} + (AWIDTH+1)'(nbytes)) > (AWIDTH+1)'(MEM_DEPTH);
  assign acc_err = f3_illegal(a_write, a_f3) || misalign || oor;
  assign commit  = !rst && (((state_q == IDLE) && accept && (LATENCY == 1)) ||
                            ((state_q == WAIT) && (cnt_q == 4'd1)));
  assign mem_we  = commit && a_write && !acc_err;

  dmem_byte_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_PATH  (MEM_PATH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (off_al[MAW-1:0]),
    .wdata_i (a_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    ext = mem_rdata;
    case (sz)
      SZ_B:    ext = {{(DWIDTH-8){mem_rdata[7] & ~a_f3[2]}}, mem_rdata[7:0]};
      SZ_H:    ext = {{(DWIDTH-16){mem_rdata[15] & ~a_f3[2]}}, mem_rdata[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          f3_d    = req_funct3_i;
          wdata_d = req_wdata_i;
          write_d = req_write_i;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rsp_valid_d = 1'b1;
      err_d       = acc_err;
      rdata_d     = (a_write || acc_err) ? '0 : ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder; honours DMEM_MISALIGN_TRAP_EN for the misaligned case.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1048576;
  localparam logic [31:0] BASE  = 32'h02000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .BASE_ADDR (BASE),
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_funct3_i (req_f3),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request and return at the first negedge after it was accepted.
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_f3    = f;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // rsp_valid must first be seen LAT cycles after the accept cycle.
  task automatic wait_valid(input string tag);
    int n;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_rd, input logic exp_err);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    send(w, a, f, d);
    wait_valid(tag);
    collect(tag, exp_rd, exp_err);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_f3    = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Word store/load round trip.
    access("sw_base", 1'b1, BASE, F3_SW, 32'hDEADBEEF, 32'h0, 1'b0);
    access("lw_base", 1'b0, BASE, F3_LW, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store into a known word, then sign/zero-extended reads.
    access("sw_w4", 1'b1, BASE + 32'd4, F3_SW, 32'h11223344, 32'h0, 1'b0);
    access("sb_b5", 1'b1, BASE + 32'd5, F3_SB, 32'h0000AB80, 32'h0, 1'b0);
    access("lb_b5", 1'b0, BASE + 32'd5, F3_LB, 32'h0, 32'hFFFFFF80, 1'b0);
    access("lbu_b5", 1'b0, BASE + 32'd5, F3_LBU, 32'h0, 32'h00000080, 1'b0);
    access("lw_w4", 1'b0, BASE + 32'd4, F3_LW, 32'h0, 32'h11228044, 1'b0);
    access("lh_b6", 1'b0, BASE + 32'd6, F3_LH, 32'h0, 32'h00001122, 1'b0);
    access("lb_b4", 1'b0, BASE + 32'd4, F3_LB, 32'h0, 32'h00000044, 1'b0);

    // Back-pressure: response held, new request ignored until handshake.
    rsp_ready = 1'b0;
    send(1'b0, BASE, F3_LW, 32'h0);
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = BASE;
        req_f3    = F3_SW;
        req_wdata = 32'hCAFE8001;
      end
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);
    access("bp_sw", 1'b1, BASE, F3_SW, 32'hCAFE8001, 32'h0, 1'b0);
    access("bp_lw", 1'b0, BASE, F3_LW, 32'h0, 32'hCAFE8001, 1'b0);

    // Out-of-range and illegal funct3 accesses fault without touching storage.
    access("oor_below", 1'b0, 32'h01FFFFFC, F3_LW, 32'h0, 32'h0, 1'b1);
    access("oor_top", 1'b0, BASE + 32'(DEPTH), F3_LW, 32'h0, 32'h0, 1'b1);
    access("oor_sw", 1'b1, BASE + 32'(DEPTH), F3_SW, 32'hBAD0BAD0, 32'h0, 1'b1);
    access("ill_ld", 1'b0, BASE, 3'b011, 32'h0, 32'h0, 1'b1);
    access("ill_st", 1'b1, BASE, 3'b101, 32'h55555555, 32'h0, 1'b1);
    access("intact", 1'b0, BASE, F3_LW, 32'h0, 32'hCAFE8001, 1'b0);

    // Misaligned halfword.
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lh_mis", 1'b0, BASE + 32'd1, F3_LH, 32'h0, 32'h0, 1'b1);
`else
    access("lh_mis", 1'b0, BASE + 32'd1, F3_LH, 32'h0, 32'hFFFF8001, 1'b0);
`endif
    access("lhu_b2", 1'b0, BASE + 32'd2, F3_LHU, 32'h0, 32'h0000CAFE, 1'b0);

    // Reset in WAIT aborts the store.
    send(1'b1, BASE, F3_SW, 32'h12345678);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_valid0", 32'(rsp_valid), 32'd0);
    chk("ab_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ab_valid1", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ab_valid2", 32'(rsp_valid), 32'd0);
    chk("ab_ready2", 32'(req_ready), 32'd1);
    access("ab_lw", 1'b0, BASE, F3_LW, 32'h0, 32'hCAFE8001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
